// File: rtl/bht_update_sched.sv
// BHT update scheduler: queues resolved-branch updates, owns the global history
// register and drives the table's read-modify-write port, including the clearing sweep.
module bht_update_sched #(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned VLEN       = 64,
  localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  input  logic                  upd_valid_i,
  input  logic [VLEN-1:0]       upd_pc_i,
  input  logic                  upd_taken_i,
  output logic                  upd_ready_o,
  output logic                  wr_en_o,
  input  logic                  wr_gnt_i,
  output logic [INDEX_BITS-1:0] wr_index_o,
  input  logic [1:0]            rd_counter_i,
  output logic                  wr_valid_o,
  output logic [1:0]            wr_counter_o,
  output logic [INDEX_BITS-1:0] ghr_o,
  output logic                  busy_o
);

  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);

  typedef enum logic {
    SWEEP,
    RUN
  } state_e;

  state_e state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  logic [INDEX_BITS-1:0] fifo_pc [FIFO_DEPTH];
  logic                  fifo_taken [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_BITS:0]     count_q;

  logic                  full, empty, push, pop;
  logic [INDEX_BITS-1:0] head_pc;
  logic                  head_taken;
  logic [1:0]            upd_counter;
  logic                  unused_pc_hi;

  // Only the low PC bits participate in the gshare index.
  assign unused_pc_hi = ^upd_pc_i[VLEN-1:INDEX_BITS];

  assign full       = (count_q == (PTR_BITS+1)'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign head_pc    = fifo_pc[rd_ptr_q];
  assign head_taken = fifo_taken[rd_ptr_q];
  assign push       = upd_valid_i && upd_ready_o;
  assign busy_o     = (state_q == SWEEP);
  assign ghr_o      = ghr_q;

  always_comb begin
    upd_counter = rd_counter_i;
    if (head_taken) begin
      if (rd_counter_i != 2'b11) upd_counter = rd_counter_i + 2'b01;
    end else begin
      if (rd_counter_i != 2'b00) upd_counter = rd_counter_i - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
      ghr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      ghr_q       <= ghr_d;
    end
  end

  // Flush overrides every other action in its cycle and restarts the sweep.
  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    ghr_d        = ghr_q;
    wr_en_o      = 1'b0;
    wr_index_o   = '0;
    wr_valid_o   = 1'b0;
    wr_counter_o = 2'b10;
    upd_ready_o  = 1'b0;
    pop          = 1'b0;
    if (flush_i) begin
      state_d     = SWEEP;
      sweep_cnt_d = '0;
      ghr_d       = '0;
    end else begin
      case (state_q)
        SWEEP: begin
          wr_en_o    = 1'b1;
          wr_index_o = sweep_cnt_q;
          if (wr_gnt_i) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
            if (sweep_cnt_q == INDEX_BITS'(NR_ENTRIES - 1)) state_d = RUN;
          end
        end
        RUN: begin
          upd_ready_o = !full;
          if (!empty) begin
            if (debug_mode_i) begin
              pop = 1'b1;
            end else begin
              wr_en_o      = 1'b1;
              wr_index_o   = ghr_q ^ head_pc;
              wr_valid_o   = 1'b1;
              wr_counter_o = upd_counter;
              if (wr_gnt_i) begin
                pop   = 1'b1;
                ghr_d = {ghr_q[INDEX_BITS-2:0], head_taken};
              end
            end
          end
        end
        default: state_d = SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= upd_pc_i[INDEX_BITS-1:0];
      fifo_taken[wr_ptr_q] <= upd_taken_i;
    end
  end

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed self-checking bench for bht_update_sched with a 16-entry table
// and a 4-deep update FIFO.
module tb_bht_update_sched;

  localparam int unsigned NR_ENTRIES = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned VLEN       = 64;
  localparam int unsigned IB         = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          debug_mode;
  logic          upd_valid;
  logic [VLEN-1:0] upd_pc;
  logic          upd_taken;
  logic          upd_ready;
  logic          wr_en;
  logic          wr_gnt;
  logic [IB-1:0] wr_index;
  logic [1:0]    rd_counter;
  logic          wr_valid;
  logic [1:0]    wr_counter;
  logic [IB-1:0] ghr;
  logic          busy;

  int checks = 0;
  int errors = 0;

  bht_update_sched #(
    .NR_ENTRIES(NR_ENTRIES),
    .FIFO_DEPTH(FIFO_DEPTH),
    .VLEN(VLEN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .debug_mode_i(debug_mode),
    .upd_valid_i(upd_valid),
    .upd_pc_i(upd_pc),
    .upd_taken_i(upd_taken),
    .upd_ready_o(upd_ready),
    .wr_en_o(wr_en),
    .wr_gnt_i(wr_gnt),
    .wr_index_o(wr_index),
    .rd_counter_i(rd_counter),
    .wr_valid_o(wr_valid),
    .wr_counter_o(wr_counter),
    .ghr_o(ghr),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [VLEN-1:0] pc, input logic taken);
    upd_valid = valid;
    upd_pc    = pc;
    upd_taken = taken;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [IB-1:0] bp_idx [4];
  logic [1:0]    bp_ctr [4];

  initial begin
    rst = 1'b1; flush = 1'b0; debug_mode = 1'b0; wr_gnt = 1'b1;
    rd_counter = 2'b10;
    applyStimulus(1'b0, '0, 1'b0);
    #3;
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_ready", upd_ready, 0);
    checkOutput("rst_wr_en", wr_en, 1);
    checkOutput("rst_index", wr_index, 0);
    checkOutput("rst_valid", wr_valid, 0);
    checkOutput("rst_counter", wr_counter, 2'b10);
    checkOutput("rst_ghr", ghr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset sweep
    for (int i = 0; i < 16; i++) begin
      checkOutput("sweep_index", wr_index, i);
      checkOutput("sweep_valid", wr_valid, 0);
      checkOutput("sweep_counter", wr_counter, 2'b10);
      checkOutput("sweep_busy", busy, 1);
      tick();
    end
    checkOutput("sweep_done_busy", busy, 0);
    checkOutput("sweep_done_ready", upd_ready, 1);

    // Single update, then a second one to the same PC
    applyStimulus(1'b1, 64'h1000_0005, 1'b1);
    rd_counter = 2'b10;
    #1;
    checkOutput("single_ready", upd_ready, 1);
    checkOutput("single_idle_wr_en", wr_en, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("single_wr_en", wr_en, 1);
    checkOutput("single_index", wr_index, 5);
    checkOutput("single_counter", wr_counter, 2'b11);
    checkOutput("single_valid", wr_valid, 1);
    checkOutput("single_ghr_pre", ghr, 0);
    tick();
    checkOutput("single_ghr_post", ghr, 1);
    applyStimulus(1'b1, 64'h1000_0005, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("second_index", wr_index, 4);
    checkOutput("second_counter", wr_counter, 2'b01);
    tick();
    checkOutput("second_ghr", ghr, 2);

    // Saturation at both ends
    applyStimulus(1'b1, 64'h0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    rd_counter = 2'b11;
    #1;
    checkOutput("sat_hi_index", wr_index, 2);
    checkOutput("sat_hi_counter", wr_counter, 2'b11);
    tick();
    checkOutput("sat_hi_ghr", ghr, 5);
    applyStimulus(1'b1, 64'h0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    rd_counter = 2'b00;
    #1;
    checkOutput("sat_lo_index", wr_index, 5);
    checkOutput("sat_lo_counter", wr_counter, 2'b00);
    rd_counter = 2'b01;
    #1;
    checkOutput("dec_01_counter", wr_counter, 2'b00);
    tick();
    checkOutput("sat_ghr", ghr, 4'hA);
    rd_counter = 2'b10;

    // Back-pressure with the grant withheld
    wr_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 64'(i + 1), (i == 1 || i == 4) ? 1'b0 : 1'b1);
      #1;
      checkOutput("bp_ready", upd_ready, (i < 4) ? 1 : 0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("bp_ghr_hold", ghr, 4'hA);
    checkOutput("bp_wr_en", wr_en, 1);
    checkOutput("bp_head_index", wr_index, 4'hB);
    bp_idx[0] = 4'hB; bp_ctr[0] = 2'b11;
    bp_idx[1] = 4'h7; bp_ctr[1] = 2'b01;
    bp_idx[2] = 4'h9; bp_ctr[2] = 2'b11;
    bp_idx[3] = 4'h1; bp_ctr[3] = 2'b11;
    wr_gnt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checkOutput("drain_wr_en", wr_en, 1);
      checkOutput("drain_index", wr_index, bp_idx[j]);
      checkOutput("drain_counter", wr_counter, bp_ctr[j]);
      checkOutput("drain_ready", upd_ready, (j == 0) ? 0 : 1);
      tick();
    end
    checkOutput("drain_empty", wr_en, 0);
    checkOutput("drain_ghr", ghr, 4'hB);

    // Debug mode drops queued updates
    wr_gnt = 1'b0;
    applyStimulus(1'b1, 64'h6, 1'b1);
    tick();
    applyStimulus(1'b1, 64'h7, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    debug_mode = 1'b1;
    wr_gnt = 1'b1;
    #1;
    checkOutput("dbg_wr_en0", wr_en, 0);
    tick();
    checkOutput("dbg_wr_en1", wr_en, 0);
    tick();
    debug_mode = 1'b0;
    #1;
    checkOutput("dbg_empty", wr_en, 0);
    checkOutput("dbg_ready", upd_ready, 1);
    checkOutput("dbg_ghr", ghr, 4'hB);

    // Flush in RUN with three queued entries
    wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'(i + 1), 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush_run_wr_en", wr_en, 0);
    checkOutput("flush_run_ready", upd_ready, 0);
    tick();
    flush = 1'b0;
    wr_gnt = 1'b1;
    #1;
    checkOutput("flush_run_ghr", ghr, 0);
    checkOutput("flush_run_busy", busy, 1);
    checkOutput("flush_run_index", wr_index, 0);
    checkOutput("flush_run_sweep_en", wr_en, 1);

    // Flush mid-sweep at index 7
    repeat (7) tick();
    checkOutput("mid_sweep_index", wr_index, 7);
    flush = 1'b1;
    #1;
    checkOutput("mid_sweep_flush_wr_en", wr_en, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("mid_sweep_restart", wr_index, 0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("restart_busy", busy, 1);
      tick();
    end
    checkOutput("restart_done_busy", busy, 0);
    checkOutput("restart_done_ready", upd_ready, 1);
    checkOutput("flush_discarded", wr_en, 0);
    checkOutput("final_ghr", ghr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
